// File: rtl/jhash_pkg.sv
// Shared types and helpers for the jhash key packer.
// JKP_BIG_ENDIAN_EN selects big-endian byte packing.
package jhash_pkg;

  localparam int WORD_W    = 64;
  localparam int LEN_W_DEF = 12;

  typedef enum logic [1:0] {
    ACCEPT,
    EMIT,
    WAIT,
    DROP
  } state_t;

  function automatic logic [WORD_W-1:0] pack_byte(
    input logic [2:0] idx,
    input logic [7:0] b
  );
`ifdef JKP_BIG_ENDIAN_EN
    return {b, 56'b0} >> {idx, 3'b0};
`else
    return {56'b0, b} << {idx, 3'b0};
`endif
  endfunction

endpackage

// File: rtl/jhash_key_buf.sv
// Key word buffer: one write port, one combinational read port.
// Contents are never reset.
module jhash_key_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jhash_key_packer.sv
// Packs a byte stream into 64-bit words and replays them to a hash core.
// Define JKP_BIG_ENDIAN_EN for big-endian packing.
module jhash_key_packer
  import jhash_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              ce,
  output logic [WORD_W-1:0] id,
  output logic              last,
  output logic [LEN_W-1:0]  len,
  input  logic              hash_done,
  output logic              busy,
  output logic              ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + 1);

  state_t state, state_n;

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [2:0]        byte_idx;
  logic [WORD_W-1:0] asm_q, asm_n;
  logic [WORD_W-1:0] id_q, rd_data;
  logic [LEN_W-1:0]  word_cnt;
  logic              xfer, full, wr_en;

  assign in_ready = (state == ACCEPT) || (state == DROP);
  assign xfer     = in_valid && in_ready;
  // next byte would open a word beyond the buffer
  assign full     = (byte_idx == 3'd0) && (wr_ptr == PW'(DEPTH));
  assign asm_n    = asm_q | pack_byte(byte_idx, in_data);
  assign wr_en    = xfer && (state == ACCEPT) && !full
                 && ((byte_idx == 3'd7) || in_last);

  assign ce   = (state == EMIT);
  assign last = ce && (LEN_W'(rd_ptr) == word_cnt - LEN_W'(1));
  assign id   = ce ? rd_data : id_q;
  assign len  = word_cnt;
  assign ovf  = xfer && in_last
             && ((state == DROP) || ((state == ACCEPT) && full));
  assign busy = (state != ACCEPT) || (wr_ptr != '0)
             || (byte_idx != 3'd0);

  jhash_key_buf #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (WORD_W)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (asm_n),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

  always_comb begin
    state_n = state;
    case (state)
      ACCEPT: begin
        if (xfer) begin
          if (full)         state_n = in_last ? ACCEPT : DROP;
          else if (in_last) state_n = EMIT;
        end
      end
      EMIT:    if (last)              state_n = WAIT;
      WAIT:    if (hash_done)         state_n = ACCEPT;
      DROP:    if (xfer && in_last)   state_n = ACCEPT;
      default:                        state_n = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCEPT;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      byte_idx <= '0;
      asm_q    <= '0;
      word_cnt <= '0;
      id_q     <= '0;
    end else begin
      state <= state_n;
      case (state)
        ACCEPT: begin
          if (xfer && full) begin
            wr_ptr   <= '0;
            byte_idx <= '0;
            asm_q    <= '0;
          end else if (xfer) begin
            byte_idx <= byte_idx + 3'd1;
            asm_q    <= wr_en ? '0 : asm_n;
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (in_last) begin
              byte_idx <= '0;
              word_cnt <= LEN_W'(wr_ptr) + LEN_W'(1);
            end
          end
        end
        EMIT: begin
          id_q   <= rd_data;
          rd_ptr <= rd_ptr + PW'(1);
        end
        WAIT: begin
          if (hash_done) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            byte_idx <= '0;
            asm_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/jhash_key_packer.md
JHASH_KEY_PACKER -- requirements
Module: jhash_key_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, giving the key buffer size in 64-bit words (legal range 2..4095).
REQ-002 SHALL have parameter LEN_W, default 12, giving the width of the word-count output.
REQ-003 SHALL have port clk, input, 1, the clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-005 SHALL have ports in_valid (input, 1), in_data (input, 8) and in_last (input, 1), forming the upstream byte stream; in_last marks the final key byte.
REQ-006 SHALL have port in_ready, output, 1, the upstream backpressure signal.
REQ-007 SHALL have ports ce (output, 1), id (output, 64), last (output, 1) and len (output, LEN_W), which drive the hash core.
REQ-008 SHALL have port hash_done, input, 1, the hash core completion level.
REQ-009 SHALL have ports busy (output, 1), meaning a key is in flight, and ovf (output, 1), a one-cycle pulse signalling a dropped oversize key.

Function
REQ-010 SHALL implement states ACCEPT, EMIT, WAIT and DROP.
REQ-011 SHALL hold in_ready=1 only in ACCEPT and DROP; a byte transfers when in_valid&in_ready.
REQ-012 SHALL pack accepted bytes into a 64-bit assembly word, with byte k of each word at id[8k+7:8k] (default order).
REQ-013 SHALL write the assembly word to buffer[wr_ptr] on the 8th byte, or on the in_last byte, in the same cycle, then increment wr_ptr.
REQ-014 SHALL zero-fill the unused upper bytes of a partial final word.
REQ-015 SHALL move from ACCEPT to EMIT on the in_last transfer, with word_cnt=wr_ptr+1 captured.
REQ-016 In EMIT, SHALL drive ce=1, id=buffer[rd_ptr] and len=word_cnt for word_cnt consecutive cycles, with no gaps.
REQ-017 SHALL assert last only on the cycle where rd_ptr==word_cnt-1; that cycle is followed by the transition to WAIT.
REQ-018 Outside EMIT, SHALL hold ce=0 and last=0, hold id at its last value, and hold len at word_cnt.
REQ-019 SHALL stay in WAIT until hash_done=1 is sampled, then go to ACCEPT with wr_ptr, rd_ptr and the assembly word cleared.
REQ-020 SHALL ignore hash_done in every state other than WAIT.
REQ-021 Latency: the first ce SHALL be 1 cycle after the in_last transfer, and the last ce SHALL be word_cnt cycles after it.
REQ-022 If a byte would start word DEPTH+1, SHALL go to DROP, discard all bytes up to and including in_last, pulse ovf on that in_last cycle, and return to ACCEPT.
REQ-023 SHALL not assert ce for a dropped key.
REQ-024 If in_last arrives on the byte that starts word DEPTH+1, SHALL pulse ovf and return directly to ACCEPT.
REQ-025 SHALL drive busy=1 in EMIT, WAIT and DROP, and in ACCEPT once at least one byte is accepted.
REQ-026 SHALL treat in_valid=0 mid-word as a stall: the partial word is held with no timeout.

Reset
REQ-027 On rst, SHALL enter ACCEPT and clear wr_ptr, rd_ptr, word_cnt and the assembly word.
REQ-028 On rst, SHALL drive ce=0, last=0, id=0, len=0, busy=0, ovf=0 and in_ready=1 on the first cycle after reset.
REQ-029 Reset during EMIT or WAIT SHALL abort the key at once, with ce=0 the next cycle.
REQ-030 Buffer contents SHALL need no reset.

Configuration
REQ-031 With JKP_BIG_ENDIAN_EN defined, SHALL place byte k at id[63-8k:56-8k] and zero-fill the low bytes of a partial word.
REQ-032 Without JKP_BIG_ENDIAN_EN, SHALL use the little-endian packing of REQ-012.

Structure
REQ-033 SHALL take the state enum, the 64-bit word width and the default LEN_W from the shared package jhash_pkg.
REQ-034 SHALL place the buffer in a single sub-module, jhash_key_buf: a simple dual-port register array with one write port and one read port and combinational read.

Verification
REQ-035 Bytes 01..08, last on 08 -> one ce cycle, id=0807060504030201, last=1, len=1.
REQ-036 Bytes 01..0B, last on 0B -> two ce cycles: id=0807060504030201, then id=00000000000B0A09; last on the 2nd cycle; len=2 on both.
REQ-037 Single byte FF with last -> id=00000000000000FF, len=1.
REQ-038 Repeat REQ-036 with JKP_BIG_ENDIAN_EN -> 0102030405060708, then 090A0B0000000000.
REQ-039 DEPTH=2 with 17 bytes -> no ce, ovf pulses on the 17th byte; a following 3-byte key emits normally.
REQ-040 Hold hash_done=0 for 20 cycles after the last ce -> in_ready=0 and busy=1 throughout; hash_done=1 -> in_ready=1 next cycle.
REQ-041 Assert rst on the 2nd EMIT cycle of a 4-word key -> ce=0 next cycle, then a clean new key emits correctly.
